pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined integer add/subtract unit for the MIPS datapath; successor to the
//   32-bit combinational adder. Splits the carry chain into STAGES registered segments, adds
//   subtract mode, signed/unsigned flags, a sideband tag and valid/ready flow control.
//   Sits between operand issue and the writeback/flag logic of the execute stage.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth = carry-chain segments; 1..WIDTH; SEG = WIDTH/STAGES bits each
//   TAG_W   5   width of sideband tag (e.g. destination register index) carried unchanged
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operand beat valid
//   in_ready   out  1       unit can accept a beat this cycle
//   op         in   1       0 = add (a+b), 1 = subtract (a-b)
//   sat        in   1       request signed saturation (see CONFIGURATION)
//   a, b       in   WIDTH   operands
//   tag_in     in   TAG_W   sideband, returned with result
//   out_valid  out  1       result beat valid
//   out_ready  in   1       consumer accepts result this cycle
//   result     out  WIDTH   sum/difference, modulo 2^WIDTH unless saturated
//   carry      out  1       raw carry-out of MSB; for subtract 1 = no borrow (a >= b unsigned)
//   overflow   out  1       signed overflow of the unsaturated operation
//   zero       out  1       result == 0 (after saturation)
//   negative   out  1       result[WIDTH-1] (after saturation)
//   tag_out    out  TAG_W   tag_in of the beat now on result
// BEHAVIOUR
//   - Reset (async, rst_n=0): all stage valid bits 0; result, flags, tag_out = 0; out_valid=0.
//     Reset mid-operation discards every in-flight beat; nothing is emitted after release.
//   - Subtract: b inverted, carry-in 1. Add: carry-in 0. Segment k (k=0 LSB) adds
//     SEG bits with carry from segment k-1 registered at end of stage k; higher operand
//     segments and lower result segments are delayed alongside in shift registers.
//   - Latency: exactly STAGES cycles from accepted input (in_valid&&in_ready) to out_valid.
//   - Global stall: advance = !out_valid || out_ready; in_ready = advance. When advance=0
//     every stage, incl. output regs, holds. Bubbles propagate (valid bit per stage).
//   - Throughput 1 beat/cycle: output accepted and new input accepted in the same cycle is legal.
//   - overflow = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]), b' = effective (possibly inverted) b.
//   - Outputs stable while out_valid && !out_ready. in_valid with in_ready=0 is ignored (no capture).
//   - STAGES=1: single registered stage, latency 1. WIDTH%STAGES != 0 is a fatal elaboration error.
// CONFIGURATION
//   ADDSUB_SAT_EN defined: when sat=1 and overflow=1, result clamps to 0x7F..F if a
//     non-negative, else 0x80..0; zero/negative recomputed from clamped value; carry/overflow
//     still report the raw operation. Saturation applied in final stage, no extra latency.
//   ADDSUB_SAT_EN undefined: sat port present but ignored; result always modulo 2^WIDTH.
// STRUCTURE
//   addsub_pkg: OP_ADD/OP_SUB localparams, flag bit-index constants (FLAG_C/V/Z/N),
//     typedef for the per-stage pipeline record (valid, op, sat, tag, partial carry).
//   Sub-module addsub_seg: one SEG-bit segment adder + its pipeline register with enable;
//     instantiated STAGES times by generate loop. Top holds skew/deskew shifts and flags.
// TESTING (defaults WIDTH=32, STAGES=4, out_ready=1 unless stated)
//   add 2+20 -> result 22, C=0 V=0 Z=0 N=0 exactly 4 cycles after acceptance, tag echoed.
//   add 0xFFFFFFFF+1 -> result 0, C=1 V=0 Z=1; add 0x7FFFFFFF+1 -> 0x80000000, V=1 N=1.
//   sub 5-25 -> 0xFFFFFFEC, C=0 N=1; sub 25-5 -> 20, C=1; sub 7-7 -> 0, C=1 Z=1.
//   back-to-back 16 random beats, out_ready toggled randomly -> in order, no loss/dup,
//     outputs held during stall, in_ready==!out_valid||out_ready every cycle.
//   rst_n pulsed low with 3 beats in flight -> out_valid 0 immediately, no stale beats later.
//   ADDSUB_SAT_EN, sat=1: 0x7FFFFFFF+1 -> 0x7FFFFFFF V=1; 0x80000000-1 -> 0x80000000 V=1;
//     sat=0 same ops -> wrapped values; repeat sweep at STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined add/subtract unit.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

  // Record is sized for the widest supported tag; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 op;
    logic                 sat;
    logic [TAG_MAX_W-1:0] tag;
    logic                 carry;
  } pipe_rec_t;

endpackage

// File: rtl/pipelined_addsub_seg.sv
// One SEG-bit slice of the carry chain: combinational segment adder plus its stage register.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic [SEG-1:0] sum_q
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chain segments with valid/ready flow.
// Optional signed saturation is compiled in when ADDSUB_SAT_EN is defined.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $fatal(1, "pipelined_addsub: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
    $fatal(1, "pipelined_addsub: TAG_W out of range");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operands travel right-shifted so the segment for the current stage is always in the low SEG bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bx_in;
    logic [WIDTH-1:0] lo_in;
    logic [WIDTH-1:0] lo_q;
    pipe_rec_t        rec_in;
    pipe_rec_t        rec_nxt;
    pipe_rec_t        rec_q;
    logic [SEG-1:0]   sum_d;
    logic [SEG-1:0]   sum_q;
    logic             cout;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign bx_in  = (op == OP_ADD) ? b : ~b;
      assign lo_in  = '0;
      assign rec_in = '{valid: in_valid, op: op, sat: sat,
                        tag: TAG_MAX_W'(tag_in), carry: (op == OP_SUB)};
    end else begin : g_body
      assign a_in   = g_st[k-1].g_fwd.a_q;
      assign bx_in  = g_st[k-1].g_fwd.bx_q;
      assign lo_in  = g_st[k-1].lo_q | (WIDTH'(g_st[k-1].sum_q) << ((k - 1) * SEG));
      assign rec_in = g_st[k-1].rec_q;
    end

    addsub_seg #(
      .SEG (SEG)
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a     (a_in[SEG-1:0]),
      .b     (bx_in[SEG-1:0]),
      .cin   (rec_in.carry),
      .sum   (sum_d),
      .cout  (cout),
      .sum_q (sum_q)
    );

    assign rec_nxt = '{valid: rec_in.valid, op: rec_in.op, sat: rec_in.sat,
                       tag: rec_in.tag, carry: cout};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rec_q <= '0;
        lo_q  <= '0;
      end else if (advance) begin
        rec_q <= rec_nxt;
        lo_q  <= lo_in;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] bx_q;
      logic             unused_sum;

      assign unused_sum = ^sum_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (advance) begin
          a_q  <= a_in >> SEG;
          bx_q <= bx_in >> SEG;
        end
      end
    end
  end

  logic [WIDTH-1:0]  raw_d;
  logic [WIDTH-1:0]  raw_q;
  logic [WIDTH-1:0]  clamp;
  logic              a_msb;
  logic              b_msb;
  logic              ovf_d;
  logic              sat_hit;
  logic              sat_hit_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;
  logic              unused_last;

  assign a_msb = g_st[LAST].a_in[SEG-1];
  assign b_msb = g_st[LAST].bx_in[SEG-1];
  assign raw_d = g_st[LAST].lo_in | (WIDTH'(g_st[LAST].sum_d) << (LAST * SEG));
  assign ovf_d = (a_msb == b_msb) && (raw_d[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
  assign sat_hit = g_st[LAST].rec_in.sat && ovf_d;
`else
  assign sat_hit = 1'b0;
`endif

  // Carry and overflow describe the raw operation; zero and negative describe what is emitted.
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_C] = g_st[LAST].cout;
    flags_d[FLAG_V] = ovf_d;
    flags_d[FLAG_Z] = !sat_hit && (raw_d == '0);
    flags_d[FLAG_N] = sat_hit ? a_msb : raw_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      sat_hit_q <= 1'b0;
    end else if (advance) begin
      flags_q   <= flags_d;
      sat_hit_q <= sat_hit;
    end
  end

  assign raw_q = g_st[LAST].lo_q | (WIDTH'(g_st[LAST].sum_q) << (LAST * SEG));
  assign clamp = {flags_q[FLAG_N], {(WIDTH-1){!flags_q[FLAG_N]}}};

  assign result    = sat_hit_q ? clamp : raw_q;
  assign out_valid = g_st[LAST].rec_q.valid;
  assign tag_out   = g_st[LAST].rec_q.tag[TAG_W-1:0];
  assign carry     = flags_q[FLAG_C];
  assign overflow  = flags_q[FLAG_V];
  assign zero      = flags_q[FLAG_Z];
  assign negative  = flags_q[FLAG_N];

  assign unused_last = ^{g_st[LAST].a_in, g_st[LAST].bx_in, g_st[LAST].rec_in, g_st[LAST].rec_q};

endmodule
